// File: rtl/chao_entropy_packer.sv
// chao_entropy_packer
//
// Packs raw 4-bit entropy samples from a chaotic extractor into OUT_WIDTH-bit
// random words and runs two continuous health tests on the accepted samples:
// a repetition count test (RCT) and an adaptive proportion test (APT). A
// health failure raises a sticky alarm that blocks output until cleared.
//
// Ports
//   i_clk        : clock for all logic
//   i_reset_n    : asynchronous assert, synchronous release, active-low reset
//   i_en         : global enable; 0 freezes collection and health counters
//   i_dat        : raw entropy nibble
//   i_valid      : i_dat carries a new sample this cycle
//   o_rnd        : packed random word
//   o_rnd_valid  : o_rnd holds a word
//   i_rnd_ready  : consumer takes o_rnd
//   o_alarm      : sticky health-test failure
//   i_alarm_clr  : single-cycle alarm clear (only acts in ALARM)
//   o_state      : debug view of the FSM state (COLLECT/STALL/ALARM)
//
// Output handshake: a word transfers on every clock edge where
// o_rnd_valid=1 and i_rnd_ready=1. While o_rnd_valid=1 and no transfer has
// happened, o_rnd is held stable. i_rnd_ready is ignored while o_rnd_valid=0.
module chao_entropy_packer #(
  parameter int OUT_WIDTH  = 32,
  parameter int RCT_CUTOFF = 8,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 24
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_en,
  input  logic [3:0]           i_dat,
  input  logic                 i_valid,
  output logic [OUT_WIDTH-1:0] o_rnd,
  output logic                 o_rnd_valid,
  input  logic                 i_rnd_ready,
  output logic                 o_alarm,
  input  logic                 i_alarm_clr,
  output logic [1:0]           o_state
);

  localparam int NIBBLES = OUT_WIDTH / 4;
  localparam int NW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int RW      = $clog2(RCT_CUTOFF + 1);
  localparam int AW      = $clog2(APT_CUTOFF + 1);
  localparam int IW      = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] STALL   = 2'd1;
  localparam logic [1:0] ALARM   = 2'd2;

  logic [1:0]           state;
  // Only the low OUT_WIDTH-4 bits of the shift register can ever reach a
  // completed word: the top nibble is shifted out on the completing sample.
  logic [OUT_WIDTH-5:0] sr;
  logic [NW-1:0]        nib_cnt;
  logic [OUT_WIDTH-1:0] held;

  logic [RW-1:0]        rct_cnt;   // 0 means no previous accepted sample
  logic [3:0]           rct_prev;
  logic [AW-1:0]        apt_cnt;
  logic [IW-1:0]        apt_idx;   // position of the next sample in the window
  logic [3:0]           apt_ref;

  logic                 accept;
  logic                 handshake;
  logic [OUT_WIDTH-1:0] shifted;
  logic                 last_nib;
  logic [RW-1:0]        rct_next;
  logic                 apt_first;
  logic [AW-1:0]        apt_next;
  logic [IW-1:0]        apt_idx_next;
  logic                 trigger;
  logic                 load_out;
  logic                 to_stall;

  always_comb begin
    accept       = i_en && i_valid && (state == COLLECT);
    handshake    = o_rnd_valid && i_rnd_ready;
    shifted      = {sr, i_dat};
    last_nib     = (nib_cnt == NW'(NIBBLES - 1));

    rct_next     = ((rct_cnt != '0) && (i_dat == rct_prev)) ? rct_cnt + RW'(1) : RW'(1);

    apt_first    = (apt_idx == '0);
    apt_next     = apt_first ? AW'(1)
                 : (i_dat == apt_ref) ? apt_cnt + AW'(1) : apt_cnt;
    apt_idx_next = (apt_idx == IW'(APT_WINDOW - 1)) ? '0 : apt_idx + IW'(1);

    // A failing sample never completes a word.
    trigger      = accept && ((rct_next == RW'(RCT_CUTOFF)) || (apt_next == AW'(APT_CUTOFF)));
    load_out     = accept && !trigger && last_nib && (!o_rnd_valid || handshake);
    to_stall     = accept && !trigger && last_nib && o_rnd_valid && !handshake;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= COLLECT;
      sr          <= '0;
      nib_cnt     <= '0;
      held        <= '0;
      o_rnd       <= '0;
      o_rnd_valid <= 1'b0;
      o_alarm     <= 1'b0;
      rct_cnt     <= '0;
      rct_prev    <= '0;
      apt_cnt     <= '0;
      apt_idx     <= '0;
      apt_ref     <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (handshake) o_rnd_valid <= 1'b0;
          if (accept) begin
            rct_cnt  <= rct_next;
            rct_prev <= i_dat;
            apt_cnt  <= apt_next;
            apt_idx  <= apt_idx_next;
            if (apt_first) apt_ref <= i_dat;
            if (trigger) begin
              // Health failure: drop everything in flight, including any
              // word still sitting on the output.
              state       <= ALARM;
              o_alarm     <= 1'b1;
              o_rnd_valid <= 1'b0;
              sr          <= '0;
              nib_cnt     <= '0;
              held        <= '0;
            end else begin
              sr      <= shifted[OUT_WIDTH-5:0];
              nib_cnt <= last_nib ? '0 : nib_cnt + NW'(1);
              if (load_out) begin
                o_rnd       <= shifted;
                o_rnd_valid <= 1'b1;
              end else if (to_stall) begin
                held  <= shifted;
                state <= STALL;
              end
            end
          end
        end
        STALL: begin
          // o_rnd_valid stays high: the held word replaces the one consumed.
          if (handshake) begin
            o_rnd <= held;
            held  <= '0;
            state <= COLLECT;
          end
        end
        ALARM: begin
          // A trigger can only occur in COLLECT and a clear only acts here,
          // so a same-cycle trigger always leaves the alarm set.
          if (i_alarm_clr) begin
            state    <= COLLECT;
            o_alarm  <= 1'b0;
            sr       <= '0;
            nib_cnt  <= '0;
            held     <= '0;
            rct_cnt  <= '0;
            rct_prev <= '0;
            apt_cnt  <= '0;
            apt_idx  <= '0;
            apt_ref  <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_chao_entropy_packer.sv
// tb_chao_entropy_packer
//
// Directed scenarios followed by a randomized run, all checked every cycle
// against a reference model that works on the accepted-sample history
// (queues of nibbles) rather than on counters.
module tb_chao_entropy_packer;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         valid = 1'b0;
  logic         ready = 1'b0;
  logic         clr = 1'b0;
  logic [3:0]   dat = 4'd0;
  logic [W-1:0] rnd;
  logic         rnd_valid;
  logic         alarm;
  logic [1:0]   state;

  always #5 clk = ~clk;

  chao_entropy_packer #(
    .OUT_WIDTH(W), .RCT_CUTOFF(8), .APT_WINDOW(64), .APT_CUTOFF(24)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_dat(dat), .i_valid(valid),
    .o_rnd(rnd), .o_rnd_valid(rnd_valid), .i_rnd_ready(ready),
    .o_alarm(alarm), .i_alarm_clr(clr), .o_state(state)
  );

  // ---------------- counters ----------------
  int total  = 0;
  int passed = 0;

  // ---------------- reference model ----------------
  bit           m_valid, m_alarm, m_stall;
  logic [W-1:0] m_rnd, m_held;
  logic [3:0]   word_q[$];   // nibbles of the word being collected
  logic [3:0]   hist[$];     // all accepted samples since reset / alarm clear
  logic [W-1:0] exp_q[$];    // completed words not yet taken by the consumer

  function automatic bit rct_fail();
    int n = hist.size();
    if (n < 8) return 1'b0;
    for (int k = 1; k < 8; k++)
      if (hist[n-1-k] !== hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit apt_fail();
    int n   = hist.size();
    int ws  = ((n - 1) / 64) * 64;
    int cnt = 0;
    for (int i = ws; i < n; i++)
      if (hist[i] == hist[ws]) cnt++;
    return (cnt == 24);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_alarm = 0; m_stall = 0; m_rnd = '0; m_held = '0;
    word_q.delete(); hist.delete(); exp_q.delete();
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit           hs, load;
    logic [W-1:0] w;
    hs   = m_valid && ready;
    load = 0;
    if (m_alarm) begin
      if (clr) begin
        m_alarm = 0; hist.delete(); word_q.delete();
      end
      return;
    end
    if (m_stall) begin
      if (hs) begin
        m_rnd = m_held; m_stall = 0;
      end
      return;
    end
    if (en && valid) begin
      hist.push_back(dat);
      if (rct_fail() || apt_fail()) begin
        m_alarm = 1; m_valid = 0; word_q.delete(); exp_q.delete();
        return;
      end
      word_q.push_back(dat);
      if (word_q.size() == W / 4) begin
        w = '0;
        foreach (word_q[i]) w = {w[W-5:0], word_q[i]};
        word_q.delete();
        exp_q.push_back(w);
        if (!m_valid || hs) begin
          m_rnd = w; m_valid = 1; load = 1;
        end else begin
          m_held = w; m_stall = 1;
        end
      end
    end
    if (hs && !load) m_valid = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    logic [1:0] exp_state;
    exp_state = m_alarm ? 2'd2 : (m_stall ? 2'd1 : 2'd0);
    cmp({tag, ".valid"}, W'(rnd_valid), W'(m_valid));
    cmp({tag, ".alarm"}, W'(alarm), W'(m_alarm));
    cmp({tag, ".state"}, W'(state), W'(exp_state));
    if (m_valid) cmp({tag, ".rnd"}, rnd, m_rnd);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit e, input bit v, input logic [3:0] d, input bit r, input bit c);
    en = e; valid = v; dat = d; ready = r; clr = c;
    // Word ordering: whatever the consumer takes must be the oldest word.
    if (m_valid && ready) begin
      if (exp_q.size() == 0) cmp("word_order_empty", rnd, '1 ^ rnd);
      else cmp("word_order", rnd, exp_q.pop_front());
    end
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_all("step");
  endtask

  // Asserts reset away from a clock edge, checks outputs with no edge in
  // between, holds over one edge, then releases away from the edge.
  task automatic do_reset();
    rst_n = 1'b0; en = 0; valid = 0; ready = 0; clr = 0;
    #1;
    model_reset();
    cmp("rst.rnd",   rnd,            '0);
    cmp("rst.valid", W'(rnd_valid),  '0);
    cmp("rst.alarm", W'(alarm),      '0);
    cmp("rst.state", W'(state),      '0);
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] apt_val(input int i, input int last_ref);
    int p = i % 64;
    return ((p % 2 == 0) && (p <= last_ref)) ? 4'hA : 4'(i % 10);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int         mode;
    logic [3:0] d;

    model_reset();
    #2;
    do_reset();

    // Nibbles 1..8 with ready high: word valid right after the 8th.
    for (int i = 1; i <= 8; i++) step(1, 1, 4'(i), 1, 0);
    cmp("seq_word", rnd, 32'h12345678);
    cmp("seq_valid", W'(rnd_valid), W'(1));
    step(1, 0, 4'h0, 1, 1);  // clear pulse outside ALARM must do nothing

    // Back-pressure: second word stalls, samples dropped, released by ready.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 1, 4'(i), 0, 0);
    cmp("stall_word", rnd, 32'h01234567);
    cmp("stall_state", W'(state), W'(1));
    for (int i = 0; i < 3; i++) step(1, 1, 4'(i + 3), 0, 0);
    step(1, 1, 4'h7, 1, 0);
    cmp("stall_release", rnd, 32'h89ABCDEF);
    cmp("stall_release_valid", W'(rnd_valid), W'(1));
    step(1, 0, 4'h0, 1, 0);

    // RCT: eight identical nibbles raise the alarm.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, 4'h5, 1, 0);
    cmp("rct_alarm", W'(alarm), W'(1));
    cmp("rct_valid", W'(rnd_valid), W'(0));
    for (int i = 0; i < 3; i++) step(1, 1, 4'(i), 1, 0);
    step(0, 0, 4'h0, 0, 1);
    cmp("rct_cleared", W'(alarm), W'(0));
    for (int i = 8; i < 16; i++) step(1, 1, 4'(i), 1, 0);
    cmp("rct_after_clr", rnd, 32'h89ABCDEF);

    // APT: 24 occurrences of the window reference -> alarm at the 24th.
    do_reset();
    for (int i = 0; i < 48; i++) step(1, 1, apt_val(i, 46), 1, 0);
    cmp("apt24_alarm", W'(alarm), W'(1));
    // 23 occurrences per window, two windows: no alarm, window restarts.
    do_reset();
    for (int i = 0; i < 128; i++) step(1, 1, apt_val(i, 44), 1, 0);
    cmp("apt23_no_alarm", W'(alarm), W'(0));

    // Reset mid-word, then a full word.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 4'(i + 9), 1, 0);
    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 1, 4'(i), 1, 0);
    cmp("rst_mid_word", rnd, 32'h12345678);
    // Reset while in ALARM.
    for (int i = 0; i < 8; i++) step(1, 1, 4'h3, 1, 0);
    cmp("pre_rst_alarm", W'(alarm), W'(1));
    do_reset();
    for (int i = 8; i < 16; i++) step(1, 1, 4'(i), 1, 0);
    cmp("rst_from_alarm", rnd, 32'h89ABCDEF);

    // Enable low mid-word freezes collection.
    do_reset();
    step(1, 1, 4'hA, 1, 0);
    step(1, 1, 4'hB, 1, 0);
    step(1, 1, 4'hC, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 4'($urandom_range(0, 15)), 1, 0);
    for (int i = 1; i <= 5; i++) step(1, 1, 4'(i), 1, 0);
    cmp("en_freeze_word", rnd, 32'hABC12345);

    // Randomized run across uniform, two-symbol and repeat-heavy phases.
    do_reset();
    mode = 0;
    d = 4'h0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) mode = $urandom_range(0, 2);
      if (mode == 1)      d = 4'($urandom_range(0, 1));
      else if (mode == 2) d = ($urandom_range(0, 9) < 6) ? d : 4'($urandom_range(0, 15));
      else                d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, d,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
